// File: rtl/hdmi_demo_sequencer_pkg.sv
// Shared state encoding and helpers for the HDMI demo power-up/recovery sequencer.
// The enum values double as the LED debug code driven on state_o.
package hdmi_demo_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_WAIT_LOCK = 3'd0,
        SEQ_HOLD      = 3'd1,
        SEQ_ENC_UP    = 3'd2,
        SEQ_RUN       = 3'd3,
        SEQ_RETRY     = 3'd4,
        SEQ_FAULT     = 3'd5
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hdmi_demo_sequencer_sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the pixclk domain.
module hdmi_demo_sequencer_sync_2ff (
    input  logic pixclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;

    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], d};
    end

    assign q = sync_q[1];

endmodule

// File: rtl/hdmi_demo_sequencer.sv
// Sequences encoder and demo resets after PLL lock, and re-sequences a demo whose
// vsync stalls, giving up into a sticky FAULT after MAX_RETRIES attempts.
module hdmi_demo_sequencer
    import hdmi_demo_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES   = 63,
    parameter int SETTLE_CYCLES = 1024,
    parameter int VSYNC_TIMEOUT = 1000000,
    parameter int MAX_RETRIES   = 3,
    parameter int GOOD_FRAMES   = 16
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       vsync,
    output logic       enc_rst_n,
    output logic       demo_rst_n,
    output logic       running,
    output logic       fault,
    output logic [2:0] retry_cnt,
    output logic [2:0] state_o
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, SETTLE_CYCLES) + 1);
    localparam int WD_W  = $clog2(VSYNC_TIMEOUT + 1);
    localparam int GD_W  = $clog2(GOOD_FRAMES + 1);

    seq_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WD_W-1:0]  wd;
    logic [GD_W-1:0]  good;
    logic             lock_s, vsync_d;
    logic             vs_edge, vs_rise, hold_done, settle_done, timeout;
    logic             enc_d, demo_d, run_d, fault_d;

    hdmi_demo_sequencer_sync_2ff u_lock_sync (
        .pixclk (pixclk),
        .rst    (rst),
        .d      (pll_locked),
        .q      (lock_s)
    );

    assign vs_edge     = vsync != vsync_d;
    assign vs_rise     = vsync & ~vsync_d;
    assign hold_done   = cnt == CNT_W'(HOLD_CYCLES - 1);
    assign settle_done = cnt == CNT_W'(SETTLE_CYCLES - 1);
    // A vsync edge in the same cycle as the timeout rescues the frame.
    assign timeout     = (wd == WD_W'(VSYNC_TIMEOUT - 1)) && !vs_edge;

    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) state <= SEQ_WAIT_LOCK;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SEQ_WAIT_LOCK: if (lock_s) state_nx = SEQ_HOLD;
            SEQ_HOLD: begin
                if (!lock_s)        state_nx = SEQ_WAIT_LOCK;
                else if (hold_done) state_nx = SEQ_ENC_UP;
            end
            SEQ_ENC_UP: begin
                if (!lock_s)          state_nx = SEQ_WAIT_LOCK;
                else if (settle_done) state_nx = SEQ_RUN;
            end
            SEQ_RUN: begin
                if (!lock_s)      state_nx = SEQ_WAIT_LOCK;
                else if (timeout) state_nx = SEQ_RETRY;
            end
            SEQ_RETRY: begin
                if (!lock_s)                         state_nx = SEQ_WAIT_LOCK;
                else if (retry_cnt == 3'(MAX_RETRIES)) state_nx = SEQ_FAULT;
                else                                 state_nx = SEQ_HOLD;
            end
            SEQ_FAULT:   state_nx = SEQ_FAULT;
            default:     state_nx = SEQ_WAIT_LOCK;
        endcase
    end

    always_comb begin
        enc_d   = (state_nx == SEQ_ENC_UP) || (state_nx == SEQ_RUN);
        demo_d  = state_nx == SEQ_RUN;
        run_d   = state_nx == SEQ_RUN;
        fault_d = state_nx == SEQ_FAULT;
    end

    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            enc_rst_n  <= 1'b0;
            demo_rst_n <= 1'b0;
            running    <= 1'b0;
            fault      <= 1'b0;
        end else begin
            enc_rst_n  <= enc_d;
            demo_rst_n <= demo_d;
            running    <= run_d;
            fault      <= fault_d;
        end
    end

    // Counters clear on any state change, so every state is entered with fresh counts.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            wd        <= '0;
            good      <= '0;
            retry_cnt <= '0;
            vsync_d   <= 1'b0;
        end else begin
            vsync_d <= vsync;
            cnt     <= '0;
            wd      <= '0;
            good    <= '0;
            if (state_nx == state) begin
                case (state)
                    SEQ_HOLD, SEQ_ENC_UP: cnt <= cnt + 1'b1;
                    SEQ_RUN: begin
                        wd   <= vs_edge ? '0 : wd + 1'b1;
                        good <= good;
                        if (vs_rise && good != GD_W'(GOOD_FRAMES)) good <= good + 1'b1;
                        if (vs_rise && good >= GD_W'(GOOD_FRAMES - 1)) retry_cnt <= '0;
                    end
                    default: ;
                endcase
            end
            if (state == SEQ_RETRY && state_nx == SEQ_HOLD) retry_cnt <= retry_cnt + 1'b1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hdmi_demo_sequencer.sv
// Directed bench for hdmi_demo_sequencer: a table of timed steps through power-up,
// retries and FAULT, then hand sequences for edge/timeout, good frames, lock loss, reset.
module tb_hdmi_demo_sequencer;

    localparam int HOLD = 8, SETTLE = 16, TMO = 100, MAXR = 2, GOOD = 4;

    logic       pixclk = 1'b0;
    logic       rst, pll_locked, vsync;
    logic       enc_rst_n, demo_rst_n, running, fault;
    logic [2:0] retry_cnt, state_o;
    logic [9:0] obs;

    int checks = 0;
    int errors = 0;

    hdmi_demo_sequencer #(
        .HOLD_CYCLES   (HOLD),
        .SETTLE_CYCLES (SETTLE),
        .VSYNC_TIMEOUT (TMO),
        .MAX_RETRIES   (MAXR),
        .GOOD_FRAMES   (GOOD)
    ) dut (
        .pixclk     (pixclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .vsync      (vsync),
        .enc_rst_n  (enc_rst_n),
        .demo_rst_n (demo_rst_n),
        .running    (running),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state_o    (state_o)
    );

    always #5 pixclk = ~pixclk;

    assign obs = {enc_rst_n, demo_rst_n, running, fault, retry_cnt, state_o};

    typedef struct {
        logic       lock;
        logic       vs;
        int         n;
        logic [9:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [9:0] e(input logic en, input logic dm, input logic rn,
                                     input logic fl, input int r, input int s);
        return {en, dm, rn, fl, 3'(r), 3'(s)};
    endfunction

    function automatic vec_t mk(input logic lock, input logic vs, input int n,
                                input logic [9:0] exp, input string name);
        vec_t v;
        v.lock = lock; v.vs = vs; v.n = n; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge pixclk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got en,dm,run,flt,retry,state=%b want %b", name, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int i = 0;
        while (state_o !== s && i < budget) begin
            tick(1);
            i++;
        end
        checks++;
        if (state_o !== s) begin
            errors++;
            $display("FAIL %s: state %0d after %0d cycles, want %0d", name, state_o, budget, s);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pll_locked = 1'b0; vsync = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        // Step table: apply inputs, run n edges, compare all outputs.
        tbl.push_back(mk(0, 0,   5, e(0,0,0,0,0,0), "wait_lock"));
        tbl.push_back(mk(1, 0,   3, e(0,0,0,0,0,1), "hold_entry"));
        tbl.push_back(mk(1, 0,   7, e(0,0,0,0,0,1), "hold_last"));
        tbl.push_back(mk(1, 0,   1, e(1,0,0,0,0,2), "enc_up"));
        tbl.push_back(mk(1, 0,  15, e(1,0,0,0,0,2), "enc_up_last"));
        tbl.push_back(mk(1, 0,   1, e(1,1,1,0,0,3), "run"));
        tbl.push_back(mk(1, 0,  99, e(1,1,1,0,0,3), "run_pre_timeout"));
        tbl.push_back(mk(1, 0,   1, e(0,0,0,0,0,4), "retry1"));
        tbl.push_back(mk(1, 0,   1, e(0,0,0,0,1,1), "hold_after_retry1"));
        tbl.push_back(mk(1, 0,  24, e(1,1,1,0,1,3), "run2"));
        tbl.push_back(mk(1, 0, 100, e(0,0,0,0,1,4), "retry2"));
        tbl.push_back(mk(1, 0,   1, e(0,0,0,0,2,1), "hold_after_retry2"));
        tbl.push_back(mk(1, 0, 124, e(0,0,0,0,2,4), "retry3"));
        tbl.push_back(mk(1, 0,   1, e(0,0,0,1,2,5), "fault"));
        tbl.push_back(mk(0, 0,   6, e(0,0,0,1,2,5), "fault_lock_lo"));
        tbl.push_back(mk(1, 0,   6, e(0,0,0,1,2,5), "fault_lock_hi"));

        rst = 1'b1; pll_locked = 1'b0; vsync = 1'b0;
        #2;
        check("reset_async", e(0,0,0,0,0,0));
        tick(2);
        rst = 1'b0;

        foreach (tbl[i]) begin
            pll_locked = tbl[i].lock;
            vsync      = tbl[i].vs;
            tick(tbl[i].n);
            check(tbl[i].name, tbl[i].exp);
        end

        #2 rst = 1'b1;
        #1 check("rst_clears_fault", e(0,0,0,0,0,0));

        // Edge arriving on the timeout cycle keeps RUN; the next full stall times out.
        do_reset();
        pll_locked = 1'b1;
        wait_state(3'd3, 60, "reach_run_a");
        tick(99);
        vsync = 1'b1;
        tick(1);
        check("edge_beats_timeout", e(1,1,1,0,0,3));
        tick(99);
        check("run_after_edge", e(1,1,1,0,0,3));
        tick(1);
        check("timeout_after_edge", e(0,0,0,0,0,4));
        tick(1);
        check("retry_hold", e(0,0,0,0,1,1));

        // GOOD rising edges in RUN clear the retry count, not one fewer.
        wait_state(3'd3, 60, "reach_run_b");
        for (int k = 0; k < GOOD; k++) begin
            vsync = 1'b0;
            tick(10);
            vsync = 1'b1;
            tick(10);
            if (k == GOOD - 2) check("good3_no_clear", e(1,1,1,0,1,3));
        end
        check("good4_clears", e(1,1,1,0,0,3));

        // Lock loss in ENC_UP and RUN keeps retry_cnt.
        wait_state(3'd4, 150, "stall_retry");
        tick(1);
        check("hold_retry_again", e(0,0,0,0,1,1));
        wait_state(3'd2, 20, "reach_enc_up");
        pll_locked = 1'b0;
        tick(3);
        check("lock_drop_enc_up", e(0,0,0,0,1,0));
        pll_locked = 1'b1;
        wait_state(3'd3, 60, "reach_run_c");
        pll_locked = 1'b0;
        tick(3);
        check("lock_drop_run", e(0,0,0,0,1,0));

        // Reset mid-cycle in RUN must act before the next clock edge.
        pll_locked = 1'b1;
        wait_state(3'd3, 60, "reach_run_d");
        tick(5);
        #2 rst = 1'b1;
        #1 check("async_rst_run", e(0,0,0,0,0,0));
        tick(2);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
